charge_sequencer: RTL and testbench
===================================

Name: charge_sequencer

Overview:
- Sequences one charging session after payment is accepted.
- Takes the accepted money amount and converts it to charge seconds.
- Divides the system clock down to a 1 s tick, counts the session timer down, drives the charge-enable output and reports completion.
- Sits between the coin/keypad control FSM, which supplies go, abort and money_in, and the charger output stage and display.

Parameters:
- TICK_DIV, 500: CLK cycles per one-second tick (500 Hz system clock).
- SEC_PER_YUAN, 2: charge seconds granted per unit of money.
- TIMER_MAX, 255: saturation value of timer.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  request to start a session with money_in; level sampled each cycle.
- abort  in  1  terminate the running session immediately.
- money_in  in  8  unsigned binary money amount, sampled when go is accepted.
- timer  out  8  remaining charge seconds.
- charging  out  1  charger enable, high only in RUN.
- done  out  1  one-cycle pulse on normal completion.
- state_viewer  out  4  current state encoding, for debug display.

Behaviour:
- Reset: rst high at a CLK edge forces the following, overriding all other inputs, including mid-session:
  - state IDLE, timer=0, charging=0, done=0, prescaler=0.
- States (state_viewer encoding): IDLE=0, RUN=1, DONE=2.
- IDLE:
  - go=1, abort=0, money_in!=0: next cycle state RUN, timer=min(money_in*SEC_PER_YUAN, TIMER_MAX), prescaler=0, charging=1.
  - Product is computed at 16 bits, then saturated.
  - go with money_in=0 is ignored; go and abort together: abort wins, stay IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle, tick fires and timer decrements by 1.
  - First decrement occurs TICK_DIV cycles after RUN entry; RUN lasts exactly T*TICK_DIV cycles for initial timer T.
  - When a tick takes timer from 1 to 0: next state DONE and charging=0 in the same cycle as timer=0.
  - abort=1: next cycle IDLE, timer=0, charging=0, prescaler=0, no done pulse.
  - abort and the final tick in the same cycle: abort wins, no done.
  - go in RUN: ignored unless TOPUP_EN is defined.
- DONE:
  - done=1 for exactly one cycle, timer=0, then IDLE unconditionally.
  - go in DONE is ignored; a new session can start from the next cycle.
- Timer never wraps below 0 and never exceeds TIMER_MAX.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro CHARGE_TOPUP_EN.
- Defined: in RUN, go=1 with money_in!=0 adds money_in*SEC_PER_YUAN to timer, saturating at TIMER_MAX.
  - If a tick occurs in the same cycle, result = sat(timer-1+added).
  - Prescaler is not cleared.
  - abort in the same cycle wins.
- Undefined: go in RUN has no effect; timer only decrements.

Decomposition:
- Package charger_pkg holds:
  - state encoding constants (IDLE, RUN, DONE as 4-bit values);
  - default SEC_PER_YUAN, TICK_DIV, TIMER_MAX;
  - the saturating add/convert function.
- Sub-module tick_prescaler:
  - parameter DIV; inputs CLK, rst, clr, en; output tick (one-cycle pulse every DIV enabled cycles).
  - Instantiated once, with clr asserted on RUN entry and on abort.

Test Plan (TICK_DIV=4 for simulation):
1. Reset: hold rst 2 cycles with go=1, money_in=5 -> timer=0, charging=0, done=0, state_viewer=0 throughout and after release until a new go.
2. Normal session: go one cycle, money_in=3 -> next cycle timer=6, charging=1, state_viewer=1.
   - Timer decrements every 4 cycles; timer=0 after 24 RUN cycles.
   - done=1 for one cycle with state_viewer=2, then state_viewer=0.
3. Boundaries:
   - go with money_in=0 -> stays IDLE.
   - go with money_in=200 -> timer=255.
   - go and abort together in IDLE -> stays IDLE.
4. Abort at timer=3 -> next cycle timer=0, charging=0, state_viewer=0, done never asserted.
   - go in RUN without the macro -> timer unchanged.
5. rst pulse mid-RUN at timer=4 -> next edge all outputs 0, IDLE.
   - A subsequent go with money_in=1 -> timer=2, normal completion.
6. With CHARGE_TOPUP_EN:
   - At timer=4, go with money_in=1 -> timer=6.
   - Repeated with a coincident tick -> timer=5.
   - At timer=250, go with money_in=10 -> timer=255.

Source files
------------

// File: rtl/charger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : charger_pkg
//  Description : Shared types, default parameters and conversion helpers for
//                the charge sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package charger_pkg;

  // Default configuration: 500 Hz system clock, 2 s per money unit.
  localparam int DEF_TICK_DIV     = 500;
  localparam int DEF_SEC_PER_YUAN = 2;
  localparam int DEF_TIMER_MAX    = 255;

  // State encoding, also exported on state_viewer for the debug display.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RUN  = 4'd1,
    ST_DONE = 4'd2
  } state_t;

  // Money to seconds; the product is kept at 16 bits so it can be saturated.
  function automatic logic [15:0] money_to_sec(input logic [7:0]  money,
                                               input logic [15:0] sec_per_unit);
    return 16'(money) * sec_per_unit;
  endfunction

  // base - dec + add, clamped to max_val. Callers never pass dec=1 with
  // base=0, so the subtraction cannot underflow.
  function automatic logic [7:0] sat_add(input logic [7:0]  base,
                                         input logic        dec,
                                         input logic [15:0] add,
                                         input logic [7:0]  max_val);
    logic [16:0] sum;
    sum = {9'd0, base} - {16'd0, dec} + {1'b0, add};
    if (sum > {9'd0, max_val}) begin
      return max_val;
    end
    return sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/charge_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : charge_sequencer_if
//  Description : Control/status bundle between the payment FSM (master) and
//                the charge sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface charge_sequencer_if;

  logic       go;
  logic       abort;
  logic [7:0] money_in;
  logic [7:0] timer;
  logic       charging;
  logic       done;
  logic [3:0] state_viewer;

  modport master (
    output go, abort, money_in,
    input  timer, charging, done, state_viewer
  );

  modport slave (
    input  go, abort, money_in,
    output timer, charging, done, state_viewer
  );

endinterface
`default_nettype wire

// File: rtl/charge_sequencer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides CLK down to a one-cycle tick every DIV enabled
//                cycles. clr restarts the count from zero.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV = 500
) (
  input  wire logic CLK,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tick
);

  localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_count;
  logic            w_wrap;

  assign w_wrap = (r_count == c_last);
  assign tick   = en & w_wrap;

  // Free-running 0..DIV-1 counter, advancing only while enabled.
  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/charge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : charge_sequencer
//  Description : Converts accepted money into charge seconds, counts them
//                down on a 1 s tick, drives charge enable and pulses done.
//                Optional top-up during a session: define CHARGE_TOPUP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module charge_sequencer
  import charger_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int SEC_PER_YUAN = DEF_SEC_PER_YUAN,
  parameter int TIMER_MAX    = DEF_TIMER_MAX
) (
  input wire logic          CLK,
  input wire logic          rst,
  charge_sequencer_if.slave bus
);

  localparam logic [7:0]  c_timer_max = 8'(TIMER_MAX);
  localparam logic [15:0] c_sec_per   = 16'(SEC_PER_YUAN);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic        r_charging;
  logic        r_done;

  state_t      w_state_next;
  logic [7:0]  w_timer_next;
  logic        w_charging_next;
  logic        w_done_next;
  logic        w_clr;
  logic        w_tick;
  logic        w_money_nz;
  logic [15:0] w_grant;
  logic [15:0] w_topup;
  logic [7:0]  w_run_timer;

  assign w_money_nz = (bus.money_in != 8'd0);
  assign w_grant    = money_to_sec(bus.money_in, c_sec_per);

`ifdef CHARGE_TOPUP_EN
  assign w_topup = (bus.go && w_money_nz) ? w_grant : 16'd0;
`else
  assign w_topup = 16'd0;
`endif

  // Timer value for a RUN cycle: tick decrement and top-up folded together.
  assign w_run_timer = sat_add(r_timer, w_tick, w_topup, c_timer_max);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .rst  (rst),
    .clr  (w_clr),
    .en   (r_state == ST_RUN),
    .tick (w_tick)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_charging_next = r_charging;
    w_done_next     = 1'b0;
    w_clr           = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_timer_next    = 8'd0;
        w_charging_next = 1'b0;
        if (bus.go && !bus.abort && w_money_nz) begin
          w_state_next    = ST_RUN;
          w_timer_next    = sat_add(8'd0, 1'b0, w_grant, c_timer_max);
          w_charging_next = 1'b1;
          w_clr           = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_next    = ST_IDLE;
          w_timer_next    = 8'd0;
          w_charging_next = 1'b0;
          w_clr           = 1'b1;
        end else if (w_run_timer == 8'd0) begin
          w_state_next    = ST_DONE;
          w_timer_next    = 8'd0;
          w_charging_next = 1'b0;
          w_done_next     = 1'b1;
        end else begin
          w_timer_next    = w_run_timer;
          w_charging_next = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next    = ST_IDLE;
        w_timer_next    = 8'd0;
        w_charging_next = 1'b0;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_timer_next    = 8'd0;
        w_charging_next = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= 8'd0;
      r_charging <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_charging <= w_charging_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.timer        = r_timer;
  assign bus.charging     = r_charging;
  assign bus.done         = r_done;
  assign bus.state_viewer = r_state;

endmodule
`default_nettype wire

// File: tb/tb_charge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_charge_sequencer
//  Description : Directed bench for charge_sequencer with TICK_DIV=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_charge_sequencer;

  logic CLK;
  logic rst;
  int   n_vec;
  int   n_err;

  charge_sequencer_if bus ();

  charge_sequencer #(
    .TICK_DIV     (4),
    .SEC_PER_YUAN (2),
    .TIMER_MAX    (255)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       go;
    logic       abort;
    logic [7:0] money;
    logic [7:0] timer;
    logic       chg;
    logic       done;
    logic [3:0] st;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic g, input logic a,
                              input logic [7:0] m, input logic [7:0] t,
                              input logic c, input logic d, input logic [3:0] s);
    vec_t v;
    v.rst = r; v.go = g; v.abort = a; v.money = m;
    v.timer = t; v.chg = c; v.done = d; v.st = s;
    return v;
  endfunction

  task automatic drive(input logic r, input logic g, input logic a, input logic [7:0] m);
    rst = r; bus.go = g; bus.abort = a; bus.money_in = m;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] t, input logic c,
                     input logic d, input logic [3:0] s);
    n_vec++;
    if (bus.timer !== t || bus.charging !== c || bus.done !== d || bus.state_viewer !== s) begin
      n_err++;
      $display("FAIL %s: got timer=%0d charging=%b done=%b state=%0d, expected timer=%0d charging=%b done=%b state=%0d",
               name, bus.timer, bus.charging, bus.done, bus.state_viewer, t, c, d, s);
    end
  endtask

  vec_t vecs[9];

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge CLK);

    // Reset and IDLE boundary cases, one vector per clock edge.
    vecs[0] = mk(1'b1, 1'b1, 1'b0, 8'd5,   8'd0,   1'b0, 1'b0, 4'd0); // rst with go
    vecs[1] = mk(1'b1, 1'b1, 1'b0, 8'd5,   8'd0,   1'b0, 1'b0, 4'd0);
    vecs[2] = mk(1'b0, 1'b0, 1'b0, 8'd5,   8'd0,   1'b0, 1'b0, 4'd0); // released, no go
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 4'd0); // money 0 ignored
    vecs[4] = mk(1'b0, 1'b1, 1'b1, 8'd5,   8'd0,   1'b0, 1'b0, 4'd0); // abort beats go
    vecs[5] = mk(1'b0, 1'b1, 1'b0, 8'd200, 8'd255, 1'b1, 1'b0, 4'd1); // saturate 400->255
    vecs[6] = mk(1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 4'd0); // abort in RUN
    vecs[7] = mk(1'b0, 1'b1, 1'b0, 8'd127, 8'd254, 1'b1, 1'b0, 4'd1); // 254 just under max
    vecs[8] = mk(1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].go, vecs[i].abort, vecs[i].money);
      step();
      chk($sformatf("vec%0d", i), vecs[i].timer, vecs[i].chg, vecs[i].done, vecs[i].st);
    end

    // Normal session, money 3 -> 6 s -> 24 RUN cycles, then done pulse.
    drive(1'b0, 1'b1, 1'b0, 8'd3);
    step();
    chk("norm_entry", 8'd6, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k < 24; k++) begin
      step();
      chk($sformatf("norm_run%0d", k), 8'(6 - k / 4), 1'b1, 1'b0, 4'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("norm_done", 8'd0, 1'b0, 1'b1, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 8'd3);                       // go during DONE ignored
    step();
    chk("norm_idle", 8'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("norm_idle2", 8'd0, 1'b0, 1'b0, 4'd0);

    // Abort at timer=3; go during RUN has no effect in the default build.
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    step();
    chk("abrt_entry", 8'd4, 1'b1, 1'b0, 4'd1);
`ifndef CHARGE_TOPUP_EN
    drive(1'b0, 1'b1, 1'b0, 8'd5);
`else
    drive(1'b0, 1'b0, 1'b0, 8'd0);
`endif
    step();
    chk("abrt_go_in_run", 8'd4, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step(); step();
    chk("abrt_k3", 8'd4, 1'b1, 1'b0, 4'd1);
    step();
    chk("abrt_t3", 8'd3, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    chk("abrt_idle", 8'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abrt_no_done", 8'd0, 1'b0, 1'b0, 4'd0);
    end

    // Abort coinciding with the final tick: abort wins, no done.
    drive(1'b0, 1'b1, 1'b0, 8'd1);
    step();
    chk("abfin_entry", 8'd2, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k < 8; k++) step();
    chk("abfin_t1", 8'd1, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    chk("abfin_idle", 8'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("abfin_no_done", 8'd0, 1'b0, 1'b0, 4'd0);

    // Reset pulse mid-RUN at timer=4, then a fresh 1-unit session.
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("rst_pre", 8'd4, 1'b1, 1'b0, 4'd1);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    chk("rst_mid", 8'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 8'd1);
    step();
    chk("rst_new_entry", 8'd2, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("rst_run%0d", k), 8'(2 - k / 4), 1'b1, 1'b0, 4'd1);
    end
    step();
    chk("rst_done", 8'd0, 1'b0, 1'b1, 4'd2);
    step();
    chk("rst_idle", 8'd0, 1'b0, 1'b0, 4'd0);

`ifdef CHARGE_TOPUP_EN
    // Top-up without a tick: 4 + 2 = 6.
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'd1);
    step();
    chk("topup_plain", 8'd6, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    // Top-up on the tick cycle: 4 - 1 + 2 = 5.
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step(); step(); step();
    chk("topup_pre_tick", 8'd4, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 8'd1);
    step();
    chk("topup_tick", 8'd5, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++) step();               // prescaler kept its phase
    chk("topup_next_tick", 8'd4, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    // Top-up saturation: 250 + 20 -> 255.
    drive(1'b0, 1'b1, 1'b0, 8'd125);
    step();
    chk("topup_250", 8'd250, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 8'd10);
    step();
    chk("topup_sat", 8'd255, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b1, 1'b1, 8'd10);                   // abort beats top-up
    step();
    chk("topup_abort", 8'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
